// File: rtl/iir_cascade.sv
// iir_cascade: STAGES first-order shift-coefficient IIR low-pass sections in
// cascade, sharing one subtract/shift/add datapath, one stage per clock.
// Optional build macro: IIR_CASCADE_ROUND_EN selects round-half-up on the
// stage delta instead of a truncating arithmetic shift.
//
// state | meaning
// IDLE  | waiting for once; sample and coefficients captured on accept
// RUN   | updating stage idx this cycle; last stage loads out and pulses done
module iir_cascade #(
  parameter int DATAWIDTH = 16,
  parameter int STAGES    = 2,
  parameter int SHIFTW    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        once,
  input  logic                        clear,
  input  logic signed [DATAWIDTH-1:0] in,
  input  logic [STAGES*SHIFTW-1:0]    coef,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  output logic signed [DATAWIDTH-1:0] out
);

  localparam int IDXW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(STAGES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state;
  logic [IDXW-1:0]             idx;
  logic signed [DATAWIDTH-1:0] x_reg;
  logic [STAGES*SHIFTW-1:0]    coef_reg;
  logic signed [DATAWIDTH-1:0] y [STAGES];

  logic signed [DATAWIDTH-1:0] xs;
  logic signed [DATAWIDTH-1:0] ys;
  logic [SHIFTW-1:0]           ks;
  logic signed [DATAWIDTH-1:0] x_cand;
  logic signed [DATAWIDTH+1:0] diff_ext;
  logic signed [DATAWIDTH+1:0] delta_ext;
  logic signed [DATAWIDTH-1:0] y_new;
  logic                        unused_delta_msbs;

  // Select the active stage operands and compute its next state.
  // diff is kept two bits wider than the data so the rounding bias cannot wrap.
  always_comb begin
    xs        = x_reg;
    ys        = '0;
    ks        = '0;
    x_cand    = x_reg;
    for (int s = 0; s < STAGES; s++) begin
      if (idx == IDXW'(s)) begin
        xs = x_cand;
        ys = y[s];
        ks = coef_reg[s*SHIFTW +: SHIFTW];
      end
      x_cand = y[s];
    end
    diff_ext = {xs[DATAWIDTH-1], xs[DATAWIDTH-1], xs}
             - {ys[DATAWIDTH-1], ys[DATAWIDTH-1], ys};
`ifdef IIR_CASCADE_ROUND_EN
    if (ks != '0) begin
      diff_ext = diff_ext + ((DATAWIDTH+2)'(1) << (ks - SHIFTW'(1)));
    end
`else
`endif
    delta_ext = diff_ext >>> ks;
    // The result lies between y[s] and x_s, so dropping the upper bits is exact.
    y_new     = ys + delta_ext[DATAWIDTH-1:0];
  end

  assign unused_delta_msbs = ^delta_ext[DATAWIDTH+1:DATAWIDTH];

  // Sequencer, stage state registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      x_reg    <= '0;
      coef_reg <= '0;
      out      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      for (int s = 0; s < STAGES; s++) y[s] <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= (state == RUN) && once;
      if (clear) begin
        for (int s = 0; s < STAGES; s++) y[s] <= '0;
        state <= IDLE;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (once) begin
              x_reg    <= in;
              coef_reg <= coef;
              idx      <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end
          end
          RUN: begin
            for (int s = 0; s < STAGES; s++) begin
              if (idx == IDXW'(s)) y[s] <= y_new;
            end
            if (idx == LAST) begin
              out   <= y_new;
              done  <= 1'b1;
              busy  <= 1'b0;
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_cascade.sv
// Directed bench for iir_cascade (STAGES=2, DATAWIDTH=16, SHIFTW=4).
module tb_iir_cascade;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               once = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] din = '0;
  logic [7:0]         coef = '0;
  logic               busy, done, overrun;
  logic signed [15:0] dout;

  int total = 0;
  int bad = 0;

  iir_cascade #(.DATAWIDTH(16), .STAGES(2), .SHIFTW(4)) dut (
    .clk(clk), .rst(rst), .once(once), .clear(clear), .in(din), .coef(coef),
    .busy(busy), .done(done), .overrun(overrun), .out(dout)
  );

  always #5 clk = ~clk;

  // Launch one update and wait (bounded) for done; lat counts edges after E0.
  task automatic do_update(input logic signed [15:0] x, input logic [7:0] k,
                           output logic signed [15:0] y, output int lat);
    @(negedge clk);
    din = x; coef = k; once = 1'b1;
    @(posedge clk); #1;
    once = 1'b0;
    lat = 0;
    while (lat < 20 && done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    y = dout;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (dout !== 16'sd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", dout); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_step();
    logic signed [15:0] y;
    int lat;
    @(negedge clk);
    din = 16'sd1000; coef = 8'h11; once = 1'b1;
    @(posedge clk); #1;
    once = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL step_busy got=%b exp=1", busy); end
    lat = 0;
    while (lat < 20 && done !== 1'b1) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 2) begin bad++; $display("FAIL step_latency got=%0d exp=2", lat); end
    total++; if (dout !== 16'sd250) begin bad++; $display("FAIL step_out got=%0d exp=250", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL step_busy_fall got=%b exp=0", busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL step_done_width got=%b exp=0", done); end
    do_update(16'sd1000, 8'h11, y, lat);
    total++; if (y !== 16'sd500) begin bad++; $display("FAIL step2_out got=%0d exp=500", y); end
  endtask

  task automatic test_bypass();
    logic signed [15:0] y;
    int lat;
    do_update(-16'sd1234, 8'h00, y, lat);
    total++; if (y !== -16'sd1234) begin bad++; $display("FAIL bypass_out got=%0d exp=-1234", y); end
    total++; if (lat != 2) begin bad++; $display("FAIL bypass_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_rounding();
    logic signed [15:0] y;
    int lat;
    logic signed [15:0] exp_pos, exp_neg;
`ifdef IIR_CASCADE_ROUND_EN
    exp_pos = 16'sd2; exp_neg = -16'sd1;
`else
    exp_pos = 16'sd1; exp_neg = -16'sd2;
`endif
    do_clear();
    do_update(16'sd3, 8'h01, y, lat);
    total++; if (y !== exp_pos) begin bad++; $display("FAIL round_pos got=%0d exp=%0d", y, exp_pos); end
    do_clear();
    do_update(-16'sd3, 8'h01, y, lat);
    total++; if (y !== exp_neg) begin bad++; $display("FAIL round_neg got=%0d exp=%0d", y, exp_neg); end
  endtask

  task automatic test_overrun();
    int dones;
    do_clear();
    @(negedge clk);
    din = 16'sd1000; coef = 8'h11; once = 1'b1;
    @(posedge clk); #1;
    din = 16'sd2000; coef = 8'h00;
    @(posedge clk); #1;
    once = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%b exp=1", overrun); end
    dones = 0;
    @(posedge clk); #1;
    if (done === 1'b1) dones++;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_width got=%b exp=0", overrun); end
    total++; if (dout !== 16'sd250) begin bad++; $display("FAIL overrun_out got=%0d exp=250", dout); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 1) begin bad++; $display("FAIL overrun_dones got=%0d exp=1", dones); end
  endtask

  task automatic test_clear_abort();
    logic signed [15:0] y;
    int lat;
    int dones;
    // stage states are y0=500, y1=250 and out=250 here
    @(negedge clk);
    din = 16'sd1000; coef = 8'h11; once = 1'b1;
    @(posedge clk); #1;
    once = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (dout !== 16'sd250) begin bad++; $display("FAIL abort_out_kept got=%0d exp=250", dout); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    do_update(16'sd1000, 8'h11, y, lat);
    total++; if (y !== 16'sd250) begin bad++; $display("FAIL abort_states_zero got=%0d exp=250", y); end
  endtask

  task automatic test_clear_with_once();
    int dones;
    @(negedge clk);
    din = 16'sd777; coef = 8'h00; once = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    once = 1'b0; clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_once_busy got=%b exp=0", busy); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL clear_once_no_done got=%0d exp=0", dones); end
    total++; if (dout !== 16'sd250) begin bad++; $display("FAIL clear_once_out got=%0d exp=250", dout); end
  endtask

  task automatic test_reset_midrun();
    logic signed [15:0] y;
    int lat;
    @(negedge clk);
    din = 16'sd1000; coef = 8'h11; once = 1'b1;
    @(posedge clk); #1;
    once = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
    total++; if (dout !== 16'sd0) begin bad++; $display("FAIL rstmid_out got=%0d exp=0", dout); end
    @(negedge clk); rst = 1'b1;
    do_update(16'sd1000, 8'h11, y, lat);
    total++; if (y !== 16'sd250) begin bad++; $display("FAIL rstmid_step got=%0d exp=250", y); end
    total++; if (lat != 2) begin bad++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_bypass();
    test_rounding();
    test_overrun();
    test_clear_abort();
    test_clear_with_once();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
